// File: rtl/sprite_pkg.sv
// Shared sprite constants and the coordinate-to-address helper for the heart ROM.
package sprite_pkg;

    localparam int HEART_W      = 50;
    localparam int HEART_H      = 50;
    localparam int HEART_ADDR_W = 12;
    localparam int PAL_W        = 3;

    localparam logic [PAL_W-1:0] PAL_TRANSPARENT = 3'd0;

    // Row-major linear address; with w=50 a synthesiser reduces y*w to (y<<5)+(y<<4)+(y<<1).
    function automatic logic [HEART_ADDR_W-1:0] sprite_addr(input logic [5:0] x,
                                                            input logic [5:0] y,
                                                            input int w);
        return HEART_ADDR_W'(32'(y) * 32'(w) + 32'(x));
    endfunction

endpackage

// File: rtl/heart_rom_arbiter_rom.sv
// Heart sprite ROM, 50x50 pixels of 3-bit palette indices with an asynchronous read.
// The image is two round lobes over a tapering point, with a small highlight on the left lobe.
module heart_rom_arbiter_rom
    import sprite_pkg::*;
#(
    parameter int ADDR_W = HEART_ADDR_W,
    parameter int DATA_W = PAL_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int L_CX     = 13;
    localparam int R_CX     = 36;
    localparam int LOBE_CY  = 13;
    localparam int LOBE_R2  = 169;
    localparam int HL_CX    = 12;
    localparam int HL_CY    = 10;
    localparam int HL_R2    = 9;
    localparam int TIP_Y    = 47;
    localparam int PAL_FILL = 2;
    localparam int PAL_SHINE = 3;

    int   row;
    int   col;
    int   dl;
    int   dr;
    int   dh;
    int   dmid;
    logic in_lobe;
    logic in_tri;
    logic in_hl;

    // Addresses past the last pixel decode to rows >= HEART_H and read as transparent.
    always_comb begin
        row  = int'(addr) / HEART_W;
        col  = int'(addr) - row * HEART_W;
        dl   = (col - L_CX) * (col - L_CX) + (row - LOBE_CY) * (row - LOBE_CY);
        dr   = (col - R_CX) * (col - R_CX) + (row - LOBE_CY) * (row - LOBE_CY);
        dh   = (col - HL_CX) * (col - HL_CX) + (row - HL_CY) * (row - HL_CY);
        dmid = 2 * col - (HEART_W - 1);
        if (dmid < 0) begin
            dmid = -dmid;
        end
        in_lobe = (dl <= LOBE_R2) || (dr <= LOBE_R2);
        in_tri  = (row >= LOBE_CY) && (dmid <= 2 * (TIP_Y - row));
        in_hl   = (dh <= HL_R2);
        data    = '0;
        if (row < HEART_H) begin
            if (in_lobe && in_hl) begin
                data = DATA_W'(PAL_SHINE);
            end else if (in_lobe || in_tri) begin
                data = DATA_W'(PAL_FILL);
            end
        end
    end

endmodule

// File: rtl/heart_rom_arbiter.sv
// Round-robin arbiter sharing the heart sprite ROM between several requesters.
// A grant in cycle T returns the palette index, tagged with the requester ID, in cycle T+2.
module heart_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SPRITE_W = HEART_W,
    parameter int SPRITE_H = HEART_H,
    parameter int ADDR_W   = HEART_ADDR_W,
    parameter int DATA_W   = PAL_W,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*6-1:0]  req_x,
    input  logic [N_REQ*6-1:0]  req_y,
    output logic [N_REQ-1:0]    gnt,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_oob
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  rot_req;
    logic              any_req;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   gnt_idx;
    logic [5:0]        sel_x;
    logic [5:0]        sel_y;
    logic              sel_oob;

    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic              s1_oob_q, s1_oob_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_oob_q, rsp_oob_d;

    logic [DATA_W-1:0] rom_data;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot_req  = '0;
        any_req  = 1'b0;
        pick_idx = '0;
        gnt      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_req[i] = req[ID_W'((i + int'(ptr_q)) % N_REQ)];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                any_req  = 1'b1;
                pick_idx = ID_W'(i);
            end
        end
        gnt_idx = ID_W'((int'(pick_idx) + int'(ptr_q)) % N_REQ);
        if (any_req) begin
            gnt[gnt_idx] = 1'b1;
        end
        ptr_d = any_req ? ID_W'((int'(gnt_idx) + 1) % N_REQ) : ptr_q;
    end

    // Out-of-range coordinates still occupy a slot but read address 0 and come back transparent.
    always_comb begin
        sel_x       = req_x[int'(gnt_idx) * 6 +: 6];
        sel_y       = req_y[int'(gnt_idx) * 6 +: 6];
        sel_oob     = (32'(sel_x) >= SPRITE_W) || (32'(sel_y) >= SPRITE_H);

        s1_valid_d  = any_req;
        s1_id_d     = any_req ? gnt_idx : s1_id_q;
        s1_addr_d   = s1_addr_q;
        s1_oob_d    = s1_oob_q;
        if (any_req) begin
            s1_addr_d = sel_oob ? '0 : ADDR_W'(sprite_addr(sel_x, sel_y, SPRITE_W));
            s1_oob_d  = sel_oob;
        end

        rsp_valid_d = s1_valid_q;
        rsp_id_d    = s1_valid_q ? s1_id_q : rsp_id_q;
        rsp_oob_d   = s1_valid_q ? s1_oob_q : rsp_oob_q;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q) begin
            rsp_data_d = s1_oob_q ? DATA_W'(PAL_TRANSPARENT) : rom_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_addr_q   <= '0;
            s1_oob_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_oob_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_addr_q   <= s1_addr_d;
            s1_oob_q    <= s1_oob_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_oob_q   <= rsp_oob_d;
        end
    end

    heart_rom_arbiter_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .addr (s1_addr_q),
        .data (rom_data)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_oob   = rsp_oob_q;

endmodule

// File: doc/heart_rom_arbiter.md
# heart_rom_arbiter

Round-robin arbiter that shares the single 50×50, 3-bit-palette heart sprite ROM between several requesters, e.g. per-life HUD icon drawers in the colour mapper. Each requester presents a sprite-local (x, y) pixel coordinate. The block grants at most one request per cycle, converts the coordinate to a linear ROM address, and returns the registered palette index tagged with the requester ID two cycles after the grant.

## Interface
- N_REQ, 4: number of requesters (2..8)
- SPRITE_W, 50: sprite width in pixels
- SPRITE_H, 50: sprite height in pixels
- ADDR_W, 12: ROM address width
- DATA_W, 3: palette index width
- Clk  in  1  single system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held until granted
- req_x  in  N_REQ×6  sprite-local column per requester
- req_y  in  N_REQ×6  sprite-local row per requester
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as req
- rsp_valid  out  1  response valid, one-cycle pulse per grant
- rsp_id  out  $clog2(N_REQ)  index of the requester the response belongs to
- rsp_data  out  DATA_W  palette index; 0 = transparent
- rsp_oob  out  1  the coordinate was outside the sprite

## Operation
- Arbitration: round-robin pointer `ptr` gives priority ptr, ptr+1, …, wrapping modulo N_REQ.
  - gnt is one-hot or zero. It is zero only when req is all zero.
  - On any grant to requester k, ptr ← (k+1) mod N_REQ. With no grant, ptr holds.
- A requester drops req, or changes x/y, only in a cycle after one where its gnt=1. Un-granted requests hold stable.
- Address: addr = y·SPRITE_W + x, computed at ADDR_W bits. For the defaults, y·50 = (y<<5)+(y<<4)+(y<<1). The maximum in-range value, 2499, fits in 12 bits.
- Out of bounds: the coordinate is OOB when x ≥ SPRITE_W or y ≥ SPRITE_H.
  - An OOB request is still granted and still consumes a slot.
  - The ROM address is forced to 0, rsp_data=0 and rsp_oob=1.
- Pipeline stage S1 registers s1_valid, s1_id, s1_addr and s1_oob.
- Pipeline stage S2 registers rsp_valid, rsp_id, rsp_data and rsp_oob. rsp_data is the ROM output for s1_addr, masked to 0 when s1_oob=1.
- No back-pressure: the consumer accepts every rsp_valid.

## Timing
- Reset values: ptr=0, s1_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_oob=0. gnt follows req combinationally, even during reset deassertion.
- Latency: a grant in cycle T produces rsp_valid=1 in cycle T+2.
- Throughput: one grant and one response per cycle, sustained indefinitely.
- Responses come out in grant order, with no reordering and no drops.
- Simultaneous requests: exactly one requester is granted per cycle, the next in ptr order. N_REQ continuously asserted requesters are each granted once every N_REQ cycles.
- Single continuous requester: granted every cycle; ptr stays at k+1.
- Reset asserted mid-operation: the S1 and S2 valids clear immediately (asynchronous). In-flight responses are lost and never emitted. ptr returns to 0. Requesters re-issue after reset.
- Response fields (rsp_id, rsp_data, rsp_oob) hold their last values while rsp_valid=0. They are meaningful only when rsp_valid=1.

## Structure
- Shared package `sprite_pkg`:
  - constants HEART_W=50, HEART_H=50, HEART_ADDR_W=12, PAL_W=3, PAL_TRANSPARENT=3'd0
  - function `sprite_addr(x, y, w)` returning the linear address
- One sub-module: the existing heart sprite ROM (2500×3, asynchronous read, 12-bit address), instantiated once and driven from s1_addr.
- Round-robin grant logic is kept inline: a rotate, fixed-priority pick and rotate back, about 30 lines. No separate module.

## Test plan
- Single request, req=0001 at x=0, y=0 → gnt=0001 the same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=ROM[0], rsp_oob=0.
- Corner and centre: req1 at (49,49), then (25,10) → ROM addresses 2499 and 525; rsp_data matches the ROM file contents; rsp_id=1 both times.
- All four requests held from reset with ptr=0 → gnt sequence 0001, 0010, 0100, 1000, 0001…; rsp_id sequence 0, 1, 2, 3, … starting at T+2; no gaps.
- Fairness: req0 held continuously, req2 asserted at cycle 3 → grants alternate 2, 0, 2, 0…; req0 is never granted twice in a row while req2 is pending.
- Out of bounds: req3 at (50,0), then (0,63) → granted; rsp_data=0 and rsp_oob=1 for both; the next in-range response has rsp_oob=0.
- Reset mid-stream: all requesters active, Reset_n pulsed low for one cycle between edges → rsp_valid drops immediately; the first grant after release goes to requester 0; rsp_valid stays 0 until two cycles after that grant.
